// File: rtl/register_file_mp_pkg.sv
// Shared constants and the write-first forwarding helper for register_file_mp.
// The optional hardwired zero register is enabled with REGFILE_ZERO_REG_EN.
package regfile_pkg;

  localparam int DEF_DW    = 32;
  localparam int DEF_DEPTH = 32;
  localparam int DEF_NRD   = 2;

  localparam int unsigned ZERO_ADDR = 0;

  // Helper operates on the widest supported operands; callers size-cast in and out.
  localparam int MAX_DW = 64;
  localparam int MAX_AW = 16;

  function automatic logic [MAX_DW-1:0] fwd_value(
    input logic [MAX_AW-1:0] ra,
    input logic              we0,
    input logic [MAX_AW-1:0] wa0,
    input logic [MAX_DW-1:0] wd0,
    input logic              we1,
    input logic [MAX_AW-1:0] wa1,
    input logic [MAX_DW-1:0] wd1,
    input logic [MAX_DW-1:0] stor
  );
    logic [MAX_DW-1:0] v;
    if (we1 && (wa1 == ra)) begin
      v = wd1;
    end else if (we0 && (wa0 == ra)) begin
      v = wd0;
    end else begin
      v = stor;
    end
    return v;
  endfunction

endpackage

// File: rtl/register_file_mp_if.sv
// Bus bundle between decode/writeback and register_file_mp.
// Master drives addresses, writes and scoreboard sets; slave returns read data.
interface register_file_mp_if
  import regfile_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int DEPTH = DEF_DEPTH,
  parameter int NRD   = DEF_NRD
);
  localparam int AW = $clog2(DEPTH);

  logic [NRD*AW-1:0] ra;
  logic [NRD*DW-1:0] rd;
  logic [NRD-1:0]    rd_pend;
  logic              we0;
  logic [AW-1:0]     wa0;
  logic [DW-1:0]     wd0;
  logic              we1;
  logic [AW-1:0]     wa1;
  logic [DW-1:0]     wd1;
  logic              sb_set;
  logic [AW-1:0]     sb_addr;

  modport master (
    output ra, we0, wa0, wd0, we1, wa1, wd1, sb_set, sb_addr,
    input  rd, rd_pend
  );

  modport slave (
    input  ra, we0, wa0, wd0, we1, wa1, wd1, sb_set, sb_addr,
    output rd, rd_pend
  );
endinterface

// File: rtl/register_file_mp_read_port.sv
// One registered read port: write-first forwarding of data and the
// post-edge pending bit of the addressed register.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] ra_i,
  input  logic          we0_i,
  input  logic [AW-1:0] wa0_i,
  input  logic [DW-1:0] wd0_i,
  input  logic          we1_i,
  input  logic [AW-1:0] wa1_i,
  input  logic [DW-1:0] wd1_i,
  input  logic [DW-1:0] stor_i,
  input  logic          pend_i,
  output logic [DW-1:0] rd_o,
  output logic          rd_pend_o
);

  logic [DW-1:0] rd_d;
  logic [DW-1:0] rd_q;
  logic          rd_pend_q;

  // Forwarded read value for the address presented this cycle.
  always_comb begin
    rd_d = DW'(fwd_value(MAX_AW'(ra_i), we0_i, MAX_AW'(wa0_i), MAX_DW'(wd0_i),
                         we1_i, MAX_AW'(wa1_i), MAX_DW'(wd1_i), MAX_DW'(stor_i)));
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q      <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      rd_q      <= rd_d;
      rd_pend_q <= pend_i;
    end
  end

  assign rd_o      = rd_q;
  assign rd_pend_o = rd_pend_q;

endmodule

// File: rtl/register_file_mp.sv
// Two-write, NRD-read register file with pending scoreboard.
// Define REGFILE_ZERO_REG_EN to hardwire register 0 to zero.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int DEPTH = DEF_DEPTH,
  parameter int NRD   = DEF_NRD
) (
  input  logic               clk,
  input  logic               rst_n,
  register_file_mp_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0]     mem_q [DEPTH];
  logic [DEPTH-1:0]  pend_q;
  logic [DEPTH-1:0]  pend_d;
  logic              we0_s;
  logic              we1_s;
  logic              sb_s;
  logic [NRD*DW-1:0] rd_s;
  logic [NRD-1:0]    rd_pend_s;

  // Gating here keeps register 0 untouched, so storage and forwarding both read zero.
`ifdef REGFILE_ZERO_REG_EN
  assign we0_s = bus.we0    && (bus.wa0     != AW'(ZERO_ADDR));
  assign we1_s = bus.we1    && (bus.wa1     != AW'(ZERO_ADDR));
  assign sb_s  = bus.sb_set && (bus.sb_addr != AW'(ZERO_ADDR));
`else
  assign we0_s = bus.we0;
  assign we1_s = bus.we1;
  assign sb_s  = bus.sb_set;
`endif

  // Scoreboard next state: writes clear, a same-cycle set wins.
  always_comb begin
    pend_d = pend_q;
    if (we0_s) begin
      pend_d[bus.wa0] = 1'b0;
    end else begin
      pend_d = pend_d;
    end
    if (we1_s) begin
      pend_d[bus.wa1] = 1'b0;
    end else begin
      pend_d = pend_d;
    end
    if (sb_s) begin
      pend_d[bus.sb_addr] = 1'b1;
    end else begin
      pend_d = pend_d;
    end
  end

  // Storage and scoreboard registers; port 1 is applied last so it wins collisions.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      pend_q <= '0;
    end else begin
      if (we0_s) begin
        mem_q[bus.wa0] <= bus.wd0;
      end
      if (we1_s) begin
        mem_q[bus.wa1] <= bus.wd1;
      end
      pend_q <= pend_d;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] ra_s;
    assign ra_s = bus.ra[k*AW +: AW];

    regfile_read_port #(.DW(DW), .AW(AW)) u_port (
      .clk       (clk),
      .rst_n     (rst_n),
      .ra_i      (ra_s),
      .we0_i     (we0_s),
      .wa0_i     (bus.wa0),
      .wd0_i     (bus.wd0),
      .we1_i     (we1_s),
      .wa1_i     (bus.wa1),
      .wd1_i     (bus.wd1),
      .stor_i    (mem_q[ra_s]),
      .pend_i    (pend_d[ra_s]),
      .rd_o      (rd_s[k*DW +: DW]),
      .rd_pend_o (rd_pend_s[k])
    );
  end

  assign bus.rd      = rd_s;
  assign bus.rd_pend = rd_pend_s;

endmodule

// File: tb/tb_register_file_mp.sv
// Randomised plus directed bench for register_file_mp against an array-based model.
module tb_register_file_mp;
  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic clk;
  logic rst_n;

  register_file_mp_if #(.DW(DW), .DEPTH(DEPTH), .NRD(NRD)) bus ();

  register_file_mp #(.DW(DW), .DEPTH(DEPTH), .NRD(NRD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Model: a read returns the register contents as they stand after the edge.
  logic [DW-1:0] m_mem [DEPTH];
  logic          m_pend [DEPTH];
  logic [DW-1:0] exp_rd [NRD];
  logic          exp_pend [NRD];

  function automatic bit writable(input logic [AW-1:0] a);
`ifdef REGFILE_ZERO_REG_EN
    return a != 5'd0;
`else
    return 1'b1;
`endif
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[i]  = '0;
        m_pend[i] = 1'b0;
      end
      for (int k = 0; k < NRD; k++) begin
        exp_rd[k]   = '0;
        exp_pend[k] = 1'b0;
      end
    end else begin
      if (bus.we0 && writable(bus.wa0)) begin
        m_mem[bus.wa0]  = bus.wd0;
        m_pend[bus.wa0] = 1'b0;
      end
      if (bus.we1 && writable(bus.wa1)) begin
        m_mem[bus.wa1]  = bus.wd1;
        m_pend[bus.wa1] = 1'b0;
      end
      if (bus.sb_set && writable(bus.sb_addr)) m_pend[bus.sb_addr] = 1'b1;
      for (int k = 0; k < NRD; k++) begin
        exp_rd[k]   = m_mem[bus.ra[k*AW +: AW]];
        exp_pend[k] = m_pend[bus.ra[k*AW +: AW]];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (check_en) begin
      for (int k = 0; k < NRD; k++) begin
        chk($sformatf("model_rd%0d", k), bus.rd[k*DW +: DW], exp_rd[k]);
        chk($sformatf("model_pend%0d", k), {31'd0, bus.rd_pend[k]}, {31'd0, exp_pend[k]});
      end
    end
  end

  task automatic idle();
    bus.we0 = 1'b0; bus.wa0 = 5'd0; bus.wd0 = 32'd0;
    bus.we1 = 1'b0; bus.wa1 = 5'd0; bus.wd1 = 32'd0;
    bus.sb_set = 1'b0; bus.sb_addr = 5'd0;
  endtask

  task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    bus.ra = {a1, a0};
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    idle();
    set_ra(5'd0, 5'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_en = 1'b1;

    // Every address reads zero after reset.
    for (int a = 0; a < DEPTH; a++) begin
      set_ra(5'(a), 5'(DEPTH - 1 - a));
      tick();
      chk("reset_rd0", bus.rd[31:0], 32'd0);
      chk("reset_rd1", bus.rd[63:32], 32'd0);
      chk("reset_pend", {30'd0, bus.rd_pend}, 32'd0);
    end

    bus.we0 = 1'b1; bus.wa0 = 5'd5; bus.wd0 = 32'hDEADBEEF;
    tick();
    idle(); set_ra(5'd5, 5'd0);
    tick();
    chk("basic_rd0", bus.rd[31:0], 32'hDEADBEEF);
    chk("basic_model", exp_rd[0], 32'hDEADBEEF);

    bus.we1 = 1'b1; bus.wa1 = 5'd7; bus.wd1 = 32'h12345678; set_ra(5'd7, 5'd5);
    tick();
    chk("fwd_rd0", bus.rd[31:0], 32'h12345678);
    chk("fwd_rd1_other", bus.rd[63:32], 32'hDEADBEEF);

    idle();
    bus.we0 = 1'b1; bus.wa0 = 5'd9; bus.wd0 = 32'hAAAA0000;
    bus.we1 = 1'b1; bus.wa1 = 5'd9; bus.wd1 = 32'h5555FFFF;
    set_ra(5'd9, 5'd9);
    tick();
    chk("coll_fwd0", bus.rd[31:0], 32'h5555FFFF);
    chk("coll_fwd1", bus.rd[63:32], 32'h5555FFFF);
    idle();
    tick();
    chk("coll_stored", bus.rd[31:0], 32'h5555FFFF);

    bus.sb_set = 1'b1; bus.sb_addr = 5'd3; set_ra(5'd3, 5'd4);
    tick();
    chk("sb_set_pend", {30'd0, bus.rd_pend}, 32'd1);
    idle();
    tick();
    chk("sb_hold_pend", {30'd0, bus.rd_pend}, 32'd1);
    bus.we0 = 1'b1; bus.wa0 = 5'd3; bus.wd0 = 32'h00000033;
    tick();
    chk("sb_clear_pend", {30'd0, bus.rd_pend}, 32'd0);
    chk("sb_clear_rd", bus.rd[31:0], 32'h00000033);
    bus.wd0 = 32'h00000044; bus.sb_set = 1'b1; bus.sb_addr = 5'd3;
    tick();
    chk("sb_setwins_pend", {30'd0, bus.rd_pend}, 32'd1);
    chk("sb_setwins_rd", bus.rd[31:0], 32'h00000044);

    // Register 0: pending set first, then overwritten.
    idle();
    bus.sb_set = 1'b1; bus.sb_addr = 5'd0; set_ra(5'd0, 5'd0);
    tick();
    idle();
    bus.we0 = 1'b1; bus.wa0 = 5'd0; bus.wd0 = 32'hFFFFFFFF;
    tick();
`ifdef REGFILE_ZERO_REG_EN
    chk("zero_rd", bus.rd[31:0], 32'd0);
`else
    chk("zero_rd", bus.rd[31:0], 32'hFFFFFFFF);
`endif
    chk("zero_pend", {31'd0, bus.rd_pend[0]}, 32'd0);

    // Reset in the middle of a write discards it.
    idle();
    bus.we0 = 1'b1; bus.wa0 = 5'd12; bus.wd0 = 32'h00000077;
    bus.sb_set = 1'b1; bus.sb_addr = 5'd12; set_ra(5'd12, 5'd5);
    rst_n = 1'b0;
    tick();
    chk("midrst_rd0", bus.rd[31:0], 32'd0);
    rst_n = 1'b1; idle();
    tick();
    chk("midrst_after_rd0", bus.rd[31:0], 32'd0);
    chk("midrst_after_rd1", bus.rd[63:32], 32'd0);
    chk("midrst_after_pend", {30'd0, bus.rd_pend}, 32'd0);

    // Randomised traffic on a narrow address window to provoke collisions.
    for (int n = 0; n < 3000; n++) begin
      rst_n       = ($urandom_range(0, 199) != 0);
      bus.we0     = $urandom_range(0, 1) == 1;
      bus.wa0     = 5'($urandom_range(0, 7));
      bus.wd0     = $urandom;
      bus.we1     = $urandom_range(0, 2) == 0;
      bus.wa1     = 5'($urandom_range(0, 7));
      bus.wd1     = $urandom;
      bus.sb_set  = $urandom_range(0, 2) == 0;
      bus.sb_addr = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) bus.ra = 10'($urandom);
      else set_ra(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      tick();
    end

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised successor to the single-write, two-read register file.
- Configurable data width, depth and read-port count; two write ports with fixed priority; registered reads with write-first forwarding.
- Adds a per-register pending scoreboard for hazard detection by the control/hazard unit.
- Sits between decode (read addresses, scoreboard set) and writeback (write ports) in the pipelined MIPS-32 datapath.

Parameters:
- DW, 32, data width in bits.
- DEPTH, 32, number of registers; power of two, at least 2.
- AW, $clog2(DEPTH), address width; derived, not overridden.
- NRD, 2, number of read ports, 1..4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- ra  in  NRD*AW  read addresses; port k uses bits [k*AW +: AW].
- rd  out  NRD*DW  registered read data; port k uses bits [k*DW +: DW].
- rd_pend  out  NRD  registered pending flag of the register addressed on each read port.
- we0  in  1  write enable, port 0.
- wa0  in  AW  write address, port 0.
- wd0  in  DW  write data, port 0.
- we1  in  1  write enable, port 1 (higher priority).
- wa1  in  AW  write address, port 1.
- wd1  in  DW  write data, port 1.
- sb_set  in  1  mark register sb_addr pending (a load or long-latency op issued).
- sb_addr  in  AW  scoreboard set address.

Behaviour:
- Reset (rst_n low at a clock edge): all DEPTH registers, rd, rd_pend and all pending bits go to 0. Reset overrides every other input in that cycle. Reset asserted mid-operation discards in-flight writes and sets that cycle.
- Write port 0: if we0, reg[wa0] <= wd0 at the edge.
- Write port 1: if we1, reg[wa1] <= wd1 at the edge.
- Write collision: we0 and we1 to the same address in the same cycle stores wd1.
- Read latency: exactly 1 cycle. rd[k] at edge N+1 reflects ra[k] sampled at edge N.
- Forwarding (write-first): if a write targets ra[k] in the same cycle, rd[k] takes the written value. Port 1 beats port 0, matching the storage priority.
- Read ports are independent. Several ports may read the same address and receive identical data.
- Scoreboard:
  - pend[i] is set by sb_set at sb_addr.
  - pend[i] is cleared by any enabled write to address i.
  - A set and a clear of the same address in the same cycle leave the bit set (the newer producer wins).
- rd_pend[k] is registered with the same latency and forwarding as rd, i.e. it reflects the post-edge scoreboard state for ra[k].
- Setting an already-pending register keeps it pending; there is no counting.
- Arithmetic: none on data. Addresses are used unsigned and are always in range by construction.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN.
- Defined: register 0 is hardwired to zero.
  - Writes to address 0 are ignored and are not forwarded.
  - rd for address 0 is always 0.
  - sb_set to address 0 is ignored, so rd_pend for address 0 is always 0.
- Undefined: register 0 is an ordinary register, with the same behaviour as all others.

Decomposition:
- Shared package regfile_pkg holds:
  - default DW, DEPTH and NRD constants;
  - the zero-register address constant;
  - a function computing the forwarded value from (ra, we0, wa0, wd0, we1, wa1, wd1, storage value).
- Sub-module: regfile_read_port (one registered read port plus forwarding and pending lookup), instantiated NRD times in a generate loop.
- Storage array and scoreboard vector stay in the top module.

Test Plan:
- Reset then read: assert rst_n=0 for one edge, read all 32 addresses on both ports -> rd=0 and rd_pend=0 for every address, one cycle after each address is presented.
- Basic write/read: write reg5=0xDEADBEEF via port 0, read ra0=5 on a later cycle -> rd port 0 = 0xDEADBEEF one cycle later.
- Same-cycle forwarding: we1=1, wa1=7, wd1=0x12345678 with ra0=7 in the same cycle -> rd port 0 = 0x12345678 at the next edge.
- Write collision: we0=1, we1=1, wa0=wa1=9, wd0=0xAAAA0000, wd1=0x5555FFFF -> stored value and forwarded rd both 0x5555FFFF.
- Scoreboard:
  - sb_set on addr 3 -> rd_pend for ra=3 reads 1.
  - Later, a write to 3 -> the same-cycle read shows rd_pend=0.
  - sb_set on 3 together with we0 to 3 -> pending stays 1.
- Zero register, with REGFILE_ZERO_REG_EN defined: write 0xFFFFFFFF to reg0 and sb_set on 0 -> rd=0 and rd_pend=0.
- Zero register, with REGFILE_ZERO_REG_EN undefined: same stimulus -> rd=0xFFFFFFFF, and rd_pend=0 because the write clears the bit.
